// File: rtl/pingpong_memi_pkg.sv
// Shared defaults and sizing helpers for the ping-pong bank ring.
package pingpong_memi_pkg;

  localparam int DW_DEF    = 128;
  localparam int AW_DEF    = 14;
  localparam int NBANK_DEF = 2;
  localparam int NBANK_MIN = 2;
  localparam int NBANK_MAX = 8;

  // Width of a bank index; a two-bank ring still needs one bit.
  function automatic int bank_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of the full-bank counter, which must reach n itself.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pingpong_memi_if.sv
// Host-write / reader bus of the ping-pong bank ring.
interface pingpong_memi_if
  import pingpong_memi_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int BW = bank_w(NBANK_DEF)
) ();

  logic          PURGE;
  logic          WCEBI;
  logic [AW-1:0] WADDRI;
  logic [DW-1:0] DI;
  logic          WCOMMIT;
  logic          WRDY;
  logic          WOVF;
  logic [BW-1:0] WBANK;
  logic          REN;
  logic [AW-1:0] RADDR;
  logic [DW-1:0] DO;
  logic          DOV;
  logic          RVALID;
  logic          RRELEASE;
  logic [BW-1:0] RBANK;

  modport master (
    output PURGE, WCEBI, WADDRI, DI, WCOMMIT, REN, RADDR, RRELEASE,
    input  WRDY, WOVF, WBANK, DO, DOV, RVALID, RBANK
  );

  modport slave (
    input  PURGE, WCEBI, WADDRI, DI, WCOMMIT, REN, RADDR, RRELEASE,
    output WRDY, WOVF, WBANK, DO, DOV, RVALID, RBANK
  );

endinterface

// File: rtl/pingpong_memi_ram.sv
// Single-port synchronous RAM, one per bank; registered read.
module memi_ram
  import pingpong_memi_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wd_i,
  output logic [DW-1:0] rd_o
);

  logic [DW-1:0] ram [2**AW];
  logic [DW-1:0] rd_q;

  // One access per cycle: write when we_i, otherwise a registered read.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) ram[addr_i] <= wd_i;
      else      rd_q        <= ram[addr_i];
    end
  end

  assign rd_o = rd_q;

endmodule

// File: rtl/pingpong_memi.sv
// Ring of NBANK banks: writer fills bank wp, commits it to the reader,
// reader drains bank rp and releases it back to the writer.
module pingpong_memi
  import pingpong_memi_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int NBANK = NBANK_DEF
) (
  input  logic            CLK,
  input  logic            RSTL,
  pingpong_memi_if.slave  bus
);

  localparam int BW = bank_w(NBANK);
  localparam int CW = cnt_w(NBANK);

  logic [BW-1:0] wp_q, wp_d, rp_q, rp_d, rsel_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wovf_q, wovf_d, dov_q;
  logic [DW-1:0] do_hold_q;
  logic          wrdy, rvalid, wr_ok, cm_ok, rl_ok, rd_ok;

  logic          we_s   [NBANK];
  logic          en_s   [NBANK];
  logic [AW-1:0] addr_s [NBANK];
  logic [DW-1:0] rdata_s[NBANK];

  function automatic logic [BW-1:0] ring_inc(input logic [BW-1:0] p);
    return (p == BW'(NBANK - 1)) ? '0 : p + BW'(1);
  endfunction

  assign wrdy   = (cnt_q < CW'(NBANK));
  assign rvalid = (cnt_q != '0);
  assign wr_ok  = ~bus.WCEBI & wrdy;
  assign cm_ok  = bus.WCOMMIT & wrdy;
  assign rl_ok  = bus.RRELEASE & rvalid;
  assign rd_ok  = bus.REN & rvalid;

  // Bank wp and bank rp only coincide when the ring is empty or full, and
  // then one side is blocked, so each single-port bank sees one access.
  for (genvar gi = 0; gi < NBANK; gi++) begin : g_ctl
    assign we_s[gi]   = wr_ok && (wp_q == BW'(gi));
    assign en_s[gi]   = we_s[gi] || (rd_ok && (rp_q == BW'(gi)));
    assign addr_s[gi] = we_s[gi] ? bus.WADDRI : bus.RADDR;
  end

  memi_ram #(.DW(DW), .AW(AW)) bank0_ram (.clk_i(CLK), .en_i(en_s[0]), .we_i(we_s[0]),
    .addr_i(addr_s[0]), .wd_i(bus.DI), .rd_o(rdata_s[0]));
  memi_ram #(.DW(DW), .AW(AW)) bank1_ram (.clk_i(CLK), .en_i(en_s[1]), .we_i(we_s[1]),
    .addr_i(addr_s[1]), .wd_i(bus.DI), .rd_o(rdata_s[1]));
  if (NBANK > 2) begin : g_b2
    memi_ram #(.DW(DW), .AW(AW)) bank2_ram (.clk_i(CLK), .en_i(en_s[2]), .we_i(we_s[2]),
      .addr_i(addr_s[2]), .wd_i(bus.DI), .rd_o(rdata_s[2]));
  end
  if (NBANK > 3) begin : g_b3
    memi_ram #(.DW(DW), .AW(AW)) bank3_ram (.clk_i(CLK), .en_i(en_s[3]), .we_i(we_s[3]),
      .addr_i(addr_s[3]), .wd_i(bus.DI), .rd_o(rdata_s[3]));
  end
  if (NBANK > 4) begin : g_b4
    memi_ram #(.DW(DW), .AW(AW)) bank4_ram (.clk_i(CLK), .en_i(en_s[4]), .we_i(we_s[4]),
      .addr_i(addr_s[4]), .wd_i(bus.DI), .rd_o(rdata_s[4]));
  end
  if (NBANK > 5) begin : g_b5
    memi_ram #(.DW(DW), .AW(AW)) bank5_ram (.clk_i(CLK), .en_i(en_s[5]), .we_i(we_s[5]),
      .addr_i(addr_s[5]), .wd_i(bus.DI), .rd_o(rdata_s[5]));
  end
  if (NBANK > 6) begin : g_b6
    memi_ram #(.DW(DW), .AW(AW)) bank6_ram (.clk_i(CLK), .en_i(en_s[6]), .we_i(we_s[6]),
      .addr_i(addr_s[6]), .wd_i(bus.DI), .rd_o(rdata_s[6]));
  end
  if (NBANK > 7) begin : g_b7
    memi_ram #(.DW(DW), .AW(AW)) bank7_ram (.clk_i(CLK), .en_i(en_s[7]), .we_i(we_s[7]),
      .addr_i(addr_s[7]), .wd_i(bus.DI), .rd_o(rdata_s[7]));
  end

  // Next ownership state; PURGE wins over any commit/release this cycle.
  always_comb begin
    wp_d   = wp_q;
    rp_d   = rp_q;
    cnt_d  = cnt_q;
    wovf_d = wovf_q;
    if (cm_ok) wp_d = ring_inc(wp_q);
    if (rl_ok) rp_d = ring_inc(rp_q);
    if (cm_ok && !rl_ok)      cnt_d = cnt_q + CW'(1);
    else if (!cm_ok && rl_ok) cnt_d = cnt_q - CW'(1);
    if (!wrdy && (!bus.WCEBI || bus.WCOMMIT)) wovf_d = 1'b1;
    if (bus.PURGE) begin
      wp_d   = '0;
      rp_d   = '0;
      cnt_d  = '0;
      wovf_d = 1'b0;
    end
  end

  // Ownership state register.
  always_ff @(posedge CLK or negedge RSTL) begin
    if (!RSTL) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      wovf_q <= 1'b0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      wovf_q <= wovf_d;
    end
  end

  // Read return: remember which bank answered and keep DO stable between reads.
  // PURGE does not touch this path, so an in-flight read still completes.
  always_ff @(posedge CLK or negedge RSTL) begin
    if (!RSTL) begin
      dov_q     <= 1'b0;
      rsel_q    <= '0;
      do_hold_q <= '0;
    end else begin
      dov_q <= rd_ok;
      if (rd_ok) rsel_q    <= rp_q;
      if (dov_q) do_hold_q <= rdata_s[rsel_q];
    end
  end

  assign bus.DO     = dov_q ? rdata_s[rsel_q] : do_hold_q;
  assign bus.DOV    = dov_q;
  assign bus.WRDY   = wrdy;
  assign bus.RVALID = rvalid;
  assign bus.WOVF   = wovf_q;
  assign bus.WBANK  = wp_q;
  assign bus.RBANK  = rp_q;

endmodule

// File: tb/tb_pingpong_memi.sv
// Scoreboard bench for pingpong_memi with two banks.
module tb_pingpong_memi;
  import pingpong_memi_pkg::*;

  localparam int DW = 128;
  localparam int AW = 14;
  localparam int NB = 2;
  localparam int BW = 1;

  logic clk  = 1'b0;
  logic rstl = 1'b0;
  always #5 clk = ~clk;

  pingpong_memi_if #(.DW(DW), .AW(AW), .BW(BW)) bus ();

  pingpong_memi #(.DW(DW), .AW(AW), .NBANK(NB)) dut (
    .CLK  (clk),
    .RSTL (rstl),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem_m [bit [AW:0]];
  int            wp_m, rp_m, cnt_m;
  bit            wovf_m;
  logic [DW-1:0] hold_m;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.PURGE    = 1'b0;
    bus.WCEBI    = 1'b1;
    bus.WADDRI   = '0;
    bus.DI       = '0;
    bus.WCOMMIT  = 1'b0;
    bus.REN      = 1'b0;
    bus.RADDR    = '0;
    bus.RRELEASE = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check_val({tag, "/wrdy"},   DW'(bus.WRDY),   DW'(cnt_m < NB));
    check_val({tag, "/rvalid"}, DW'(bus.RVALID), DW'(cnt_m > 0));
    check_val({tag, "/wbank"},  DW'(bus.WBANK),  DW'(wp_m));
    check_val({tag, "/rbank"},  DW'(bus.RBANK),  DW'(rp_m));
    check_val({tag, "/wovf"},   DW'(bus.WOVF),   DW'(wovf_m));
  endtask

  // One clock of stimulus: update the model, push expected read data,
  // then check state and any returned read data after the edge.
  task automatic step(input string tag, input bit wce_n, input int waddr, input logic [DW-1:0] di,
                      input bit wcommit, input bit ren, input int raddr, input bit rrelease,
                      input bit purge);
    bit wrdy_m, rvalid_m, rd, ca, ra;
    bit [AW:0] wkey, rkey;
    logic [DW-1:0] exp_do;
    wrdy_m   = (cnt_m < NB);
    rvalid_m = (cnt_m > 0);
    wkey = {wp_m[0], waddr[AW-1:0]};
    rkey = {rp_m[0], raddr[AW-1:0]};

    bus.PURGE    = purge;
    bus.WCEBI    = wce_n;
    bus.WADDRI   = waddr[AW-1:0];
    bus.DI       = di;
    bus.WCOMMIT  = wcommit;
    bus.REN      = ren;
    bus.RADDR    = raddr[AW-1:0];
    bus.RRELEASE = rrelease;

    if (!wce_n && wrdy_m) mem_m[wkey] = di;
    rd = ren && rvalid_m;
    if (rd) exp_q.push_back(mem_m.exists(rkey) ? mem_m[rkey] : 'x);
    ca = wcommit && wrdy_m;
    ra = rrelease && rvalid_m;
    if (!wrdy_m && (!wce_n || wcommit)) wovf_m = 1'b1;
    if (ca) wp_m = (wp_m + 1) % NB;
    if (ra) rp_m = (rp_m + 1) % NB;
    cnt_m = cnt_m + int'(ca) - int'(ra);
    if (purge) begin
      wp_m = 0; rp_m = 0; cnt_m = 0; wovf_m = 1'b0;
    end

    @(posedge clk);
    #1;
    check_state(tag);
    check_val({tag, "/dov"}, DW'(bus.DOV), DW'(rd));
    if (bus.DOV) begin
      if (exp_q.size() == 0) begin
        check_val({tag, "/unexpected_dov"}, DW'(1), DW'(0));
      end else begin
        exp_do = exp_q.pop_front();
        check_val({tag, "/do"}, bus.DO, exp_do);
        hold_m = exp_do;
      end
    end else begin
      check_val({tag, "/do_hold"}, bus.DO, hold_m);
    end
    $display("txn %-12s wp=%0d rp=%0d cnt=%0d wovf=%0d dov=%0d do=%h",
             tag, wp_m, rp_m, cnt_m, wovf_m, bus.DOV, bus.DO);
    drive_idle();
  endtask

  task automatic model_reset();
    wp_m = 0; rp_m = 0; cnt_m = 0; wovf_m = 1'b0; hold_m = '0;
    exp_q.delete();
  endtask

  initial begin
    bit wce_n, wcm, ren, rrel, prg;
    int wa, ra;
    logic [DW-1:0] d;

    drive_idle();
    model_reset();
    rstl = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_state("reset");
    check_val("reset/do",  bus.DO, '0);
    check_val("reset/dov", DW'(bus.DOV), '0);
    rstl = 1'b1;
    @(posedge clk);
    #1;

    // Basic write, commit, read back.
    step("wr_a5",     0, 3, DW'(128'hA5), 0, 0, 0, 0, 0);
    step("commit0",   1, 0, '0,           1, 0, 0, 0, 0);
    step("rd_a5",     1, 0, '0,           0, 1, 3, 0, 0);
    step("idle0",     1, 0, '0,           0, 0, 0, 0, 0);

    // Fill the ring, then overflow by write and by commit.
    step("wr_b1",     0, 5, DW'(128'h1234), 0, 0, 0, 0, 0);
    step("commit1",   1, 0, '0,             1, 0, 0, 0, 0);
    step("ovf_wr",    0, 3, DW'(128'hDEAD), 0, 0, 0, 0, 0);
    step("rd_keep",   1, 0, '0,             0, 1, 3, 0, 0);

    // Full ring: commit ignored, release accepted.
    step("cm_rl_full", 1, 0, '0, 1, 0, 0, 1, 0);

    // One full bank: write+commit+release+read all together.
    step("cm_rl_one", 0, 9, DW'(128'h77), 1, 1, 5, 1, 0);
    step("rd_77",     1, 0, '0,           0, 1, 9, 0, 0);
    step("rd_a5_b",   1, 0, '0,           0, 1, 3, 0, 0);

    // Purge with release and an in-flight read; memory survives.
    step("purge",     1, 0, '0, 0, 1, 9, 1, 1);
    step("rd_empty",  1, 0, '0, 0, 1, 9, 0, 0);
    step("commit_p",  1, 0, '0, 1, 0, 0, 0, 0);
    step("rd_kept",   1, 0, '0, 0, 1, 9, 0, 0);
    step("rd_kept3",  1, 0, '0, 0, 1, 3, 0, 0);

    // Random traffic over a small address window.
    for (int i = 0; i < 300; i++) begin
      bit [AW:0] rkey;
      wce_n = ($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1;
      wa    = $urandom_range(0, 7);
      ra    = $urandom_range(0, 7);
      d     = {$urandom, $urandom, $urandom, $urandom};
      wcm   = ($urandom_range(0, 4) == 0);
      rrel  = ($urandom_range(0, 4) == 0);
      prg   = ($urandom_range(0, 59) == 0);
      rkey  = {rp_m[0], ra[AW-1:0]};
      ren   = ($urandom_range(0, 1) == 1) && mem_m.exists(rkey);
      step($sformatf("rnd%0d", i), wce_n, wa, d, wcm, ren, ra, rrel, prg);
    end

    // Asynchronous reset in the middle of a cycle.
    step("pre_rst_cm", 1, 0, '0, 1, 0, 0, 0, 0);
    #2;
    rstl = 1'b0;
    #1;
    model_reset();
    check_state("async_rst");
    check_val("async_rst/do",  bus.DO, '0);
    check_val("async_rst/dov", DW'(bus.DOV), '0);
    @(posedge clk);
    #1;
    rstl = 1'b1;
    step("post_rst",   1, 0, '0, 0, 1, 0, 0, 0);
    step("post_rst_c", 1, 0, '0, 1, 0, 0, 0, 0);
    step("post_rst_r", 1, 0, '0, 0, 1, 9, 0, 0);
    step("post_rst_i", 1, 0, '0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
